// File: rtl/cnn_pkg.sv
// cnn_pkg: shared feeder state encoding, pixel width and counter-width helpers for the conv pipeline
package cnn_pkg;
    typedef enum logic {FILL = 1'b0, WRITE = 1'b1} feed_state_t;
    localparam int DEF_DATA_BITS = 8;
    localparam int PIX_BITS = DEF_DATA_BITS;
    localparam int DEF_W = 24;
    localparam int DEF_H = 24;
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int tally_bits(input int n);
        return $clog2(n + 1);
    endfunction
    localparam int COL_BITS = cnt_bits(DEF_W);
    localparam int ROW_BITS = tally_bits(DEF_H);
endpackage

// File: rtl/row_packer_feeder.sv
// row_packer_feeder: packs W serial pixels into one row word per FIFO write and counts rows per frame.
// Optional FEEDER_LAST_CHECK_EN adds sticky o_err for s_last framing mismatches.
module row_packer_feeder
    import cnn_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int H = DEF_H,
    parameter int DATA_BITS = PIX_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_BITS-1:0]     s_data,
    input  logic                     s_last,
    input  logic                     i_full,
    output logic                     o_wen,
    output logic [W*DATA_BITS-1:0]   o_wdata,
    output logic [tally_bits(H)-1:0] o_row_cnt,
`ifdef FEEDER_LAST_CHECK_EN
    output logic                     o_err,
`endif
    output logic                     o_frame_done
);
    localparam int CB = cnt_bits(W);
    localparam int RB = tally_bits(H);
    localparam logic [CB-1:0] COL_MAX = CB'(W - 1);
    localparam logic [RB-1:0] ROW_MAX = RB'(H - 1);
    feed_state_t state;
    logic [CB-1:0] col;
    logic [RB-1:0] rows;
    logic [W*DATA_BITS-1:0] row_q, row_nxt;
    logic accept, last_col;
    assign s_ready = state == FILL && !reset;
    assign accept = s_valid && s_ready;
    assign last_col = col == COL_MAX;
    // the write is combinational in WRITE, but never in a reset cycle
    assign o_wen = state == WRITE && !i_full && !reset;
    assign o_row_cnt = rows + RB'(o_wen);
    assign o_frame_done = o_wen && rows == ROW_MAX;
    always_comb begin
        row_nxt = row_q;
        row_nxt[col*DATA_BITS +: DATA_BITS] = s_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            col <= '0;
            rows <= '0;
            row_q <= '0;
            o_wdata <= '0;
        end else if (state == FILL) begin
            if (accept) begin
                row_q <= row_nxt;
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) begin
                    o_wdata <= row_nxt;
                    state <= WRITE;
                end
            end
        end else if (!i_full) begin
            rows <= rows == ROW_MAX ? '0 : rows + 1'b1;
            state <= FILL;
        end
    end
`ifdef FEEDER_LAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            o_err <= 1'b0;
        else if (accept && s_last != (rows == ROW_MAX && last_col))
            o_err <= 1'b1;
    end
`else
    logic unused_last;
    assign unused_last = s_last;
`endif
endmodule

// File: tb/tb_row_packer_feeder.sv
// tb_row_packer_feeder: directed stimulus with a pixel/row scoreboard model for row_packer_feeder (W=4, H=2)
module tb_row_packer_feeder;
    localparam int W = 4;
    localparam int H = 2;
    logic clk = 1'b0;
    logic reset, s_valid, s_ready, s_last, i_full, o_wen, o_frame_done;
    logic [7:0] s_data;
    logic [W*8-1:0] o_wdata;
    logic [1:0] o_row_cnt;
`ifdef FEEDER_LAST_CHECK_EN
    logic o_err;
`endif
    int tests = 0;
    int fails = 0;
    bit started = 0;
    always #5 clk = ~clk;

    row_packer_feeder #(.W(W), .H(H), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .i_full(i_full), .o_wen(o_wen),
        .o_wdata(o_wdata), .o_row_cnt(o_row_cnt),
`ifdef FEEDER_LAST_CHECK_EN
        .o_err(o_err),
`endif
        .o_frame_done(o_frame_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pixels collected into a pending row; a pending row blocks input until written.
    int n = 0;
    int rows = 0;
    bit pending = 0;
    bit err = 0;
    bit ewen, eready;
    logic [W*8-1:0] acc, word_out;
    always @(negedge clk) if (started) begin
        if (reset) begin
            chk("rst_ready", s_ready, 0);
            chk("rst_wen", o_wen, 0);
            n = 0; rows = 0; pending = 0; err = 0;
        end else begin
            eready = !pending;
            ewen = pending && !i_full;
            chk("ready", s_ready, eready);
            chk("wen", o_wen, ewen);
            chk("row_cnt", o_row_cnt, rows + int'(ewen));
            chk("frame_done", o_frame_done, ewen && rows == H - 1);
            if (ewen) chk("wdata", o_wdata, word_out);
`ifdef FEEDER_LAST_CHECK_EN
            chk("err", o_err, err);
`endif
            if (ewen) begin
                pending = 0;
                rows = (rows == H - 1) ? 0 : rows + 1;
            end
            if (s_valid && eready) begin
                if (s_last != (rows == H - 1 && n == W - 1)) err = 1;
                acc[n*8 +: 8] = s_data;
                if (n == W - 1) begin
                    word_out = acc;
                    pending = 1;
                    n = 0;
                end else n++;
            end
        end
    end

    task automatic send_row(input logic [7:0] b, input bit lastr, input int bad);
        for (int i = 0; i < W; i++) begin
            s_valid = 1'b1;
            s_data = b + 8'(i);
            s_last = (lastr && i == W - 1) || i == bad;
            tick();
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; i_full = 1'b0;
        @(posedge clk);
        started = 1;
        #1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", s_ready, 1);
        chk("post_rst_row_cnt", o_row_cnt, 0);
        chk("post_rst_wdata", o_wdata, 0);
        chk("post_rst_fd", o_frame_done, 0);
        tick();
        send_row(8'h01, 0, -1);
        @(negedge clk);
        chk("r1_wen", o_wen, 1);
        chk("r1_wdata", o_wdata, 32'h04030201);
        chk("r1_row_cnt", o_row_cnt, 1);
        chk("r1_ready", s_ready, 0);
        tick();
        send_row(8'h05, 1, -1);
        @(negedge clk);
        chk("r2_wdata", o_wdata, 32'h08070605);
        chk("r2_fd", o_frame_done, 1);
        chk("r2_row_cnt", o_row_cnt, 2);
        tick();
        @(negedge clk);
        chk("r2_wrap", o_row_cnt, 0);
        tick();
        i_full = 1'b1;
        send_row(8'h31, 0, -1);
        s_valid = 1'b1;
        s_data = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_wen", o_wen, 0);
            chk("bp_ready", s_ready, 0);
            tick();
        end
        i_full = 1'b0;
        @(negedge clk);
        chk("bp_wen_late", o_wen, 1);
        chk("bp_wdata", o_wdata, 32'h34333231);
        tick();
        send_row(8'h21, 1, -1);
        @(negedge clk);
        chk("aa_wdata", o_wdata, 32'h24232221);
        chk("aa_fd", o_frame_done, 1);
        tick();
        s_valid = 1'b1; s_data = 8'h51; tick();
        s_data = 8'h52; tick();
        s_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_row(8'h11, 0, -1);
        @(negedge clk);
        chk("rr_wdata", o_wdata, 32'h14131211);
        chk("rr_row_cnt", o_row_cnt, 1);
        tick();
`ifdef FEEDER_LAST_CHECK_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_row(8'h61, 0, 2);
        @(negedge clk);
        chk("err_set", o_err, 1);
        chk("err_wdata", o_wdata, 32'h64636261);
        tick();
        send_row(8'h71, 1, -1);
        @(negedge clk);
        chk("err_sticky", o_err, 1);
        chk("err_wdata2", o_wdata, 32'h74737271);
        tick();
`endif
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
